load_store_monitor: RTL and testbench
=====================================

LOAD_STORE_MONITOR -- requirements
Module: load_store_monitor

Interface
REQ-001 SHALL have parameter EXP_PERIOD, default 20002; expected cycles between consecutive sig_in rising edges.
REQ-002 SHALL have parameter EXP_HIGH, default 2; expected sig_in high width in cycles.
REQ-003 SHALL have parameter TOL, default 0; allowed +/- deviation on period, in cycles.
REQ-004 SHALL have parameter LOCK_CNT, default 3; consecutive good periods required to lock.
REQ-005 SHALL have parameter PBITS, default 16; period counter width.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-008 SHALL have port enable, input, 1, monitor run enable.
REQ-009 SHALL have port sig_in, input, 1, full indication from the load/store volume counter.
REQ-010 SHALL have port locked, output, 1, LOCKED state indicator.
REQ-011 SHALL have port err, output, 1, sticky error flag.
REQ-012 SHALL have port err_code, output, 2, first error cause: 0 none, 1 period, 2 width, 3 timeout.
REQ-013 SHALL have port last_period, output, PBITS, most recently measured period.
REQ-014 SHALL have port good_cnt, output, 16, count of good periods, saturating at 0xFFFF.

Function
REQ-015 SHALL register sig_in once (prev) and define rise = sig_in & ~prev and fall = ~sig_in & prev.
REQ-016 SHALL implement FSM states IDLE, SYNC, MEASURE, LOCKED, ERROR.
REQ-017 SHALL transition IDLE->SYNC when enable=1, and any state->IDLE when enable=0, clearing err, err_code, locked, good_cnt and counters.
REQ-018 SHALL transition SYNC->MEASURE on the first rise, zeroing the period and high counters in that cycle.
REQ-019 SHALL, in MEASURE/LOCKED, increment the period counter every cycle, saturating at all-ones.
REQ-020 SHALL increment the high counter while sig_in=1 and check it on fall: mismatch with EXP_HIGH -> ERROR, code 2.
REQ-021 SHALL, on rise, latch period counter+1 into last_period and compare with EXP_PERIOD+/-TOL: in range -> good_cnt+1; out of range -> ERROR, code 1.
REQ-022 SHALL transition MEASURE->LOCKED on the rise at which the consecutive-good count reaches LOCK_CNT; locked SHALL assert the following cycle.
REQ-023 SHALL flag a timeout (ERROR, code 3) when the period counter exceeds EXP_PERIOD+TOL with no rise.
REQ-024 SHALL record only the first error in err_code when several occur; same-cycle priority is timeout > period > width.
REQ-025 SHALL hold ERROR, with err=1 and locked=0, until rst or enable=0.
REQ-026 SHALL ignore a fall seen in SYNC, since the pulse start was not observed.

Reset
REQ-027 SHALL, on rst, set state IDLE, prev=0, locked=0, err=0, err_code=0, last_period=0, good_cnt=0, and all counters 0.
REQ-028 SHALL give rst priority over enable and sig_in in the same cycle; rst mid-measurement SHALL discard the partial period.

Configuration
REQ-029 SHALL, with LSM_STATS_EN defined, add outputs min_period and max_period (PBITS each), reset to all-ones and 0 and updated on every rise in MEASURE/LOCKED.
REQ-030 SHALL, without LSM_STATS_EN, have neither those ports nor their registers; all other behaviour is identical.

Structure
REQ-031 SHALL take the state enum, err_code enum and default constants (EXP_PERIOD=2*N+2, N=10000) from shared package load_store_pkg.
REQ-032 SHALL place rise/fall detection in sub-module lsm_edge_det (clk, rst, d, rise, fall).

Verification
REQ-033 SHALL verify, with EXP_PERIOD=10, EXP_HIGH=2, LOCK_CNT=3, a generator of period 10 and width 2: locked=1 one cycle after the 4th rise, good_cnt=3, err=0.
REQ-034 SHALL verify that a 3-cycle pulse after lock gives err=1, err_code=2, locked=0 the cycle after the fall.
REQ-035 SHALL verify that a period of 11 with TOL=0 gives err_code=1 and last_period=11; with TOL=1 the same period gives no error.
REQ-036 SHALL verify that sig_in stuck at 0 after lock gives err_code=3 once the period counter reaches 11.
REQ-037 SHALL verify that simultaneous width and timeout errors give err_code=3; a later period error leaves err_code unchanged.
REQ-038 SHALL verify that rst asserted mid-period gives all outputs 0 next cycle, and relock follows the 4th subsequent rise.

Source files
------------

// File: rtl/load_store_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_pkg                                                       |
// | Shared types and default constants for the load/store full-signal    |
// | period/width monitor.                                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package load_store_pkg;

  // Volume counter depth; the full indication repeats every 2*N+2 cycles.
  localparam int LSM_N          = 10000;
  localparam int LSM_EXP_PERIOD = 2 * LSM_N + 2;
  localparam int LSM_EXP_HIGH   = 2;
  localparam int LSM_TOL        = 0;
  localparam int LSM_LOCK_CNT   = 3;
  localparam int LSM_PBITS      = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_ERROR   = 3'd4
  } lsm_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PERIOD  = 2'd1,
    ERR_WIDTH   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } lsm_err_e;

  // Increment that sticks at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsm_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsm_edge_det                                                         |
// | Registers the input once and flags its rising and falling edges.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsm_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic r_prev;

  // One-cycle history of the monitored input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= d;
    end
  end

  assign rise = d & ~r_prev;
  assign fall = ~d & r_prev;

endmodule
`default_nettype wire

// File: rtl/load_store_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_monitor                                                   |
// | Watches the full indication of the load/store volume counter, checks |
// | its period and high width, locks after LOCK_CNT good periods and     |
// | latches the first error cause.                                       |
// | Optional: define LSM_STATS_EN to add min_period/max_period outputs.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_store_monitor
  import load_store_pkg::*;
#(
  parameter int EXP_PERIOD = LSM_EXP_PERIOD,
  parameter int EXP_HIGH   = LSM_EXP_HIGH,
  parameter int TOL        = LSM_TOL,
  parameter int LOCK_CNT   = LSM_LOCK_CNT,
  parameter int PBITS      = LSM_PBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [PBITS-1:0] last_period,
  output logic [15:0]      good_cnt
`ifdef LSM_STATS_EN
  ,
  output logic [PBITS-1:0] min_period,
  output logic [PBITS-1:0] max_period
`endif
);

  localparam int               c_HI_I   = EXP_PERIOD + TOL;
  localparam int               c_LO_I   = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam logic [PBITS-1:0] c_PER_HI = PBITS'(c_HI_I);
  localparam logic [PBITS-1:0] c_PER_LO = PBITS'(c_LO_I);
  localparam logic [PBITS-1:0] c_HIGH   = PBITS'(EXP_HIGH);
  localparam logic [PBITS-1:0] c_ONE    = PBITS'(1);
  localparam logic [16:0]      c_LOCK   = 17'(LOCK_CNT);

  lsm_state_e       r_state;
  lsm_err_e         r_err_code;
  logic             r_locked;
  logic             r_err;
  logic [PBITS-1:0] r_last_period;
  logic [15:0]      r_good_cnt;
  logic [PBITS-1:0] r_period_cnt;
  logic [PBITS-1:0] r_high_cnt;

  logic             w_rise;
  logic             w_fall;
  logic [PBITS-1:0] w_meas;
  logic [PBITS-1:0] w_width;
  logic             w_per_ok;
  logic             w_timeout;
  logic             w_width_bad;
  logic [16:0]      w_good_next;
  logic             w_lock_hit;
  logic             w_err_hit;
  lsm_err_e         w_err_cause;

  lsm_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (w_rise),
    .fall (w_fall)
  );

  // The period counter restarts at 0 in the rise cycle, so the true period
  // and pulse width are one more than the counts seen at the next edge.
  assign w_meas      = (r_period_cnt == '1) ? r_period_cnt : r_period_cnt + c_ONE;
  assign w_width     = (r_high_cnt == '1) ? r_high_cnt : r_high_cnt + c_ONE;
  assign w_per_ok    = (w_meas >= c_PER_LO) && (w_meas <= c_PER_HI);
  assign w_timeout   = !w_rise && (r_period_cnt > c_PER_HI);
  assign w_width_bad = w_fall && (w_width != c_HIGH);
  assign w_good_next = {1'b0, r_good_cnt} + 17'd1;
  assign w_lock_hit  = (w_good_next >= c_LOCK);

  // Same-cycle error arbitration: timeout beats period beats width.
  always_comb begin
    w_err_hit   = 1'b0;
    w_err_cause = ERR_NONE;
    if (w_timeout) begin
      w_err_hit   = 1'b1;
      w_err_cause = ERR_TIMEOUT;
    end else if (w_rise && !w_per_ok) begin
      w_err_hit   = 1'b1;
      w_err_cause = ERR_PERIOD;
    end else if (w_width_bad) begin
      w_err_hit   = 1'b1;
      w_err_cause = ERR_WIDTH;
    end
  end

  // Monitor FSM with its counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_err_code    <= ERR_NONE;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_last_period <= '0;
      r_good_cnt    <= '0;
      r_period_cnt  <= '0;
      r_high_cnt    <= '0;
    end else if (!enable) begin
      r_state      <= ST_IDLE;
      r_err_code   <= ERR_NONE;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_good_cnt   <= '0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_SYNC;
        end
        ST_SYNC: begin
          // A fall here belongs to a pulse whose start was never seen.
          if (w_rise) begin
            r_state      <= ST_MEASURE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (w_rise) begin
            r_period_cnt  <= '0;
            r_high_cnt    <= '0;
            r_last_period <= w_meas;
          end else begin
            if (r_period_cnt != '1) begin
              r_period_cnt <= r_period_cnt + c_ONE;
            end
            if (sig_in && (r_high_cnt != '1)) begin
              r_high_cnt <= r_high_cnt + c_ONE;
            end
          end

          if (w_err_hit) begin
            r_state  <= ST_ERROR;
            r_err    <= 1'b1;
            r_locked <= 1'b0;
            if (r_err_code == ERR_NONE) begin
              r_err_code <= w_err_cause;
            end
          end else if (w_rise) begin
            r_good_cnt <= sat_inc16(r_good_cnt);
            if ((r_state == ST_MEASURE) && w_lock_hit) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          r_state  <= ST_ERROR;
          r_locked <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign locked      = r_locked;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign last_period = r_last_period;
  assign good_cnt    = r_good_cnt;

`ifdef LSM_STATS_EN
  logic [PBITS-1:0] r_min_period;
  logic [PBITS-1:0] r_max_period;

  // Track the extremes of every period measured while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_period <= '1;
      r_max_period <= '0;
    end else if (enable && w_rise &&
                 ((r_state == ST_MEASURE) || (r_state == ST_LOCKED))) begin
      if (w_meas < r_min_period) begin
        r_min_period <= w_meas;
      end
      if (w_meas > r_max_period) begin
        r_max_period <= w_meas;
      end
    end
  end

  assign min_period = r_min_period;
  assign max_period = r_max_period;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_monitor.sv
`default_nettype none
// Bench for load_store_monitor: two instances (TOL=0 and TOL=1) share one
// stimulus stream; a timestamp-based model predicts every output each cycle.
module tb_load_store_monitor;

  localparam int P = 10;
  localparam int H = 2;
  localparam int L = 3;

  localparam int M_IDLE = 0;
  localparam int M_SYNC = 1;
  localparam int M_RUN  = 2;
  localparam int M_LOCK = 3;
  localparam int M_ERR  = 4;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        enable = 1'b0;
  logic        sig_in = 1'b0;
  logic [1:0]  lk;
  logic [1:0]  er;
  logic [3:0]  ec;
  logic [31:0] lp;
  logic [31:0] gc;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  int m_mode  [2];
  int m_trise [2];
  int m_good  [2];
  int m_code  [2];
  int m_last  [2];
  bit m_lock  [2];
  bit m_errf  [2];
  bit m_prev;
  int tol_of  [2] = '{0, 1};

  always #5 clk = ~clk;

  load_store_monitor #(.EXP_PERIOD(P), .EXP_HIGH(H), .TOL(0), .LOCK_CNT(L), .PBITS(16)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
    .locked(lk[0]), .err(er[0]), .err_code(ec[1:0]),
    .last_period(lp[15:0]), .good_cnt(gc[15:0])
  );

  load_store_monitor #(.EXP_PERIOD(P), .EXP_HIGH(H), .TOL(1), .LOCK_CNT(L), .PBITS(16)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
    .locked(lk[1]), .err(er[1]), .err_code(ec[3:2]),
    .last_period(lp[31:16]), .good_cnt(gc[31:16])
  );

  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm, i, cyc, act, exp);
    end
  endtask

  task automatic model_fail(input int i, input int code);
    m_mode[i] = M_ERR;
    m_errf[i] = 1'b1;
    m_lock[i] = 1'b0;
    if (m_code[i] == 0) m_code[i] = code;
  endtask

  // Behavioural model: periods and widths are differences of cycle stamps.
  task automatic model_update(input bit r, input bit e, input bit s);
    bit rise;
    bit fall;
    rise = s && !m_prev;
    fall = !s && m_prev;
    for (int i = 0; i < 2; i++) begin
      int el;
      bit tmo;
      bit ok_p;
      if (r) begin
        m_mode[i] = M_IDLE; m_lock[i] = 0; m_errf[i] = 0;
        m_code[i] = 0; m_last[i] = 0; m_good[i] = 0;
      end else if (!e) begin
        m_mode[i] = M_IDLE; m_lock[i] = 0; m_errf[i] = 0;
        m_code[i] = 0; m_good[i] = 0;
      end else if (m_mode[i] == M_IDLE) begin
        m_mode[i] = M_SYNC;
      end else if (m_mode[i] == M_SYNC) begin
        if (rise) begin
          m_mode[i]  = M_RUN;
          m_trise[i] = cyc;
        end
      end else if (m_mode[i] == M_RUN || m_mode[i] == M_LOCK) begin
        el   = cyc - m_trise[i];
        // The running count lags the elapsed cycles by one.
        tmo  = !rise && ((el - 1) > (P + tol_of[i]));
        ok_p = (el >= P - tol_of[i]) && (el <= P + tol_of[i]);
        if (rise) m_last[i] = el;
        if (tmo) model_fail(i, 3);
        else if (rise && !ok_p) model_fail(i, 1);
        else if (fall && (el != H)) model_fail(i, 2);
        else if (rise) begin
          m_good[i] = (m_good[i] >= 65535) ? 65535 : m_good[i] + 1;
          if (m_mode[i] == M_RUN && m_good[i] >= L) begin
            m_mode[i] = M_LOCK;
            m_lock[i] = 1'b1;
          end
        end
        if (rise) m_trise[i] = cyc;
      end
    end
    m_prev = r ? 1'b0 : s;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      cmp("locked",      i, 32'(lk[i]),           32'(m_lock[i]));
      cmp("err",         i, 32'(er[i]),           32'(m_errf[i]));
      cmp("err_code",    i, 32'(ec[2*i +: 2]),    m_code[i]);
      cmp("last_period", i, 32'(lp[16*i +: 16]),  m_last[i]);
      cmp("good_cnt",    i, 32'(gc[16*i +: 16]),  m_good[i]);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s);
    rst = r; enable = e; sig_in = s;
    @(posedge clk);
    model_update(r, e, s);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic pulse(input int per, input int wid);
    for (int k = 0; k < per; k++) step(1'b0, 1'b1, k < wid);
  endtask

  task automatic relock();
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (4) pulse(P, H);
  endtask

  initial begin
    m_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_trise[i] = 0; m_good[i] = 0;
      m_code[i] = 0; m_last[i] = 0; m_lock[i] = 0; m_errf[i] = 0;
    end

    // Reset state.
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cmp("rst_locked", i, 32'(lk[i]), 0);
      cmp("rst_err",    i, 32'(er[i]), 0);
      cmp("rst_code",   i, 32'(ec[2*i +: 2]), 0);
      cmp("rst_last",   i, 32'(lp[16*i +: 16]), 0);
      cmp("rst_good",   i, 32'(gc[16*i +: 16]), 0);
    end

    // Lock one cycle after the 4th rise.
    step(0, 1, 0);
    repeat (3) pulse(P, H);
    step(0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      cmp("lock_locked", i, 32'(lk[i]), 1);
      cmp("lock_good",   i, 32'(gc[16*i +: 16]), 3);
      cmp("lock_err",    i, 32'(er[i]), 0);
      cmp("lock_last",   i, 32'(lp[16*i +: 16]), 10);
    end
    step(0, 1, 1);
    repeat (8) step(0, 1, 0);

    // Period 11: error at TOL=0, accepted at TOL=1.
    pulse(P + 1, H);
    step(0, 1, 1);
    cmp("p11_code",  0, 32'(ec[1:0]), 1);
    cmp("p11_last",  0, 32'(lp[15:0]), 11);
    cmp("p11_lock",  0, 32'(lk[0]), 0);
    cmp("p11_err",   1, 32'(er[1]), 0);
    cmp("p11_last",  1, 32'(lp[31:16]), 11);
    cmp("p11_good",  1, 32'(gc[31:16]), 5);
    step(0, 1, 1);
    repeat (8) step(0, 1, 0);

    // 3-cycle pulse after lock: width error the cycle after the fall.
    relock();
    repeat (3) step(0, 1, 1);
    step(0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      cmp("w3_err",    i, 32'(er[i]), 1);
      cmp("w3_code",   i, 32'(ec[2*i +: 2]), 2);
      cmp("w3_locked", i, 32'(lk[i]), 0);
    end
    repeat (6) step(0, 1, 0);

    // sig_in stuck low after lock: timeout.
    relock();
    repeat (2) step(0, 1, 0);
    cmp("to_early", 0, 32'(er[0]), 0);
    step(0, 1, 0);
    cmp("to_code",  0, 32'(ec[1:0]), 3);
    cmp("to_lock",  0, 32'(lk[0]), 0);
    cmp("to_tol1",  1, 32'(er[1]), 0);
    step(0, 1, 0);
    cmp("to_code",  1, 32'(ec[3:2]), 3);

    // Width and timeout together; a later period error changes nothing.
    relock();
    repeat (12) step(0, 1, 1);
    step(0, 1, 0);
    cmp("both_code", 0, 32'(ec[1:0]), 3);
    cmp("both_code", 1, 32'(ec[3:2]), 2);
    repeat (3) step(0, 1, 0);
    step(0, 1, 1);
    cmp("later_code", 0, 32'(ec[1:0]), 3);
    cmp("later_code", 1, 32'(ec[3:2]), 2);
    cmp("later_err",  0, 32'(er[0]), 1);
    step(0, 1, 0);

    // rst mid-period, then relock on the 4th rise afterwards.
    relock();
    step(0, 1, 1); step(0, 1, 1);
    repeat (3) step(0, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      cmp("mrst_locked", i, 32'(lk[i]), 0);
      cmp("mrst_err",    i, 32'(er[i]), 0);
      cmp("mrst_code",   i, 32'(ec[2*i +: 2]), 0);
      cmp("mrst_last",   i, 32'(lp[16*i +: 16]), 0);
      cmp("mrst_good",   i, 32'(gc[16*i +: 16]), 0);
    end
    step(0, 1, 0);
    repeat (3) pulse(P, H);
    cmp("relock_pre", 0, 32'(lk[0]), 0);
    step(0, 1, 1);
    cmp("relock",     0, 32'(lk[0]), 1);
    cmp("relock_gd",  0, 32'(gc[15:0]), 3);
    step(0, 1, 1);
    repeat (8) step(0, 1, 0);

    // Randomized traffic checked by the model on every cycle.
    for (int n = 0; n < 300; n++) begin
      int sel;
      int per;
      int wid;
      sel = $urandom_range(0, 19);
      per = (sel < 12) ? P : (sel < 15) ? P + 1 : (sel < 17) ? P - 1 : (sel < 18) ? P + 3 : P + 6;
      wid = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : H;
      if ($urandom_range(0, 29) == 0) step(1, 1, 0);
      else if (m_errf[0] && m_errf[1] && ($urandom_range(0, 1) == 1)) step(0, 0, 0);
      else if ($urandom_range(0, 39) == 0) step(0, 0, 0);
      pulse(per, wid);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
